// File: rtl/svc_rv_stage_mem_pkg.sv
// Shared RISC-V definitions for the MEM stage: funct3 load/store encodings, instruction constants,
// hold-buffer state type and the alignment check.
package svc_rv_stage_mem_pkg;

   localparam logic [31:0] RV_NOP    = 32'h0000_0013;
   localparam logic [31:0] RV_EBREAK = 32'h0010_0073;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      HOLD_IDLE,
      HOLD_HELD
   } hold_state_t;

   // funct3[1:0] carries the access size for both loads and stores
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
      logic mis;
      mis = 1'b0;
      if (funct3[1:0] == F3_LH[1:0]) mis = addr[0];
      else if (funct3[1:0] == F3_LW[1:0]) mis = (addr != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/svc_rv_stage_mem_if.sv
// Data-memory port between the MEM stage (master) and the memory (slave).
// Read data returns one cycle after dmem_ren; writes complete in the cycle dmem_we is high.
interface svc_rv_stage_mem_if #(
   parameter int XLEN = 32
);
   logic            dmem_ren;
   logic [XLEN-1:0] dmem_raddr;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_waddr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_wstrb;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_ren, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb,
      output dmem_rdata
   );
endinterface

// File: rtl/svc_rv_ld_ext.sv
// Load lane selection and sign/zero extension; purely combinational, no backpressure.
module svc_rv_ld_ext
   import svc_rv_stage_mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (addr)
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = addr[1] ? word[31:16] : word[15:0];

      data = word;
      case (funct3[1:0])
         F3_LB[1:0]: data = {{(XLEN-8){byte_sel[7] & ~funct3[2]}}, byte_sel};
         F3_LH[1:0]: data = {{(XLEN-16){half_sel[15] & ~funct3[2]}}, half_sel};
         default:    data = word;
      endcase
   end

endmodule

// File: rtl/svc_rv_stage_mem.sv
// MEM stage: issues dmem access, registers MEM/WB, extends load data (1 cycle to WB).
// stall_mem holds MEM/WB and parks returning load data in a hold buffer; stall beats flush.
module svc_rv_stage_mem
   import svc_rv_stage_mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_mem,
   input  logic [31:0]          instr_mem,
   input  logic [2:0]           res_src_mem,
   input  logic [2:0]           funct3_mem,
   input  logic                 mem_read_mem,
   input  logic                 mem_write_mem,
   input  logic                 trap_mem,
   input  logic [XLEN-1:0]      alu_result_mem,
   input  logic [XLEN-1:0]      rs1_data_mem,
   input  logic [XLEN-1:0]      rs2_data_mem,
   input  logic [XLEN-1:0]      pc_plus4_mem,
   input  logic [XLEN-1:0]      jb_target_mem,
   input  logic [XLEN-1:0]      csr_rdata_mem,
   input  logic [XLEN-1:0]      m_result_mem,
   input  logic [63:0]          product_64_mem,
   input  logic                 stall_mem,
   input  logic                 flush_mem,
   svc_rv_stage_mem_if.master   dmem,
   output logic                 valid_wb,
   output logic [31:0]          instr_wb,
   output logic [2:0]           res_src_wb,
   output logic [2:0]           funct3_wb,
   output logic                 trap_wb,
   output logic [XLEN-1:0]      alu_result_wb,
   output logic [XLEN-1:0]      rs1_data_wb,
   output logic [XLEN-1:0]      rs2_data_wb,
   output logic [XLEN-1:0]      pc_plus4_wb,
   output logic [XLEN-1:0]      jb_target_wb,
   output logic [XLEN-1:0]      csr_rdata_wb,
   output logic [XLEN-1:0]      m_result_wb,
   output logic [63:0]          product_64_wb,
   output logic [XLEN-1:0]      dmem_rdata_ext_wb
);

   logic            advance;
   logic            keep;
   logic            misaligned;
   logic            mem_ok;
   logic [XLEN-1:0] st_data;
   logic [3:0]      st_strb;
   logic            ld_pend;
   hold_state_t     hold_st;
   logic [XLEN-1:0] held_q;
   logic [XLEN-1:0] ld_word;

   assign advance    = ~stall_mem;
   assign keep       = valid_mem & ~flush_mem;
   assign misaligned = is_misaligned(funct3_mem, alu_result_mem[1:0]);
   assign mem_ok     = advance & keep & ~misaligned & ~rst;

   // Accesses fire only on the advancing cycle, so a stalled store cannot repeat
   assign dmem.dmem_ren   = mem_ok & mem_read_mem;
   assign dmem.dmem_we    = mem_ok & mem_write_mem;
   assign dmem.dmem_raddr = {alu_result_mem[XLEN-1:2], 2'b00};
   assign dmem.dmem_waddr = {alu_result_mem[XLEN-1:2], 2'b00};
   assign dmem.dmem_wdata = st_data;
   assign dmem.dmem_wstrb = dmem.dmem_we ? st_strb : 4'b0000;

   always_comb begin
      st_data = rs2_data_mem;
      st_strb = 4'b1111;
      case (funct3_mem[1:0])
         F3_SB[1:0]: begin
            st_data = {4{rs2_data_mem[7:0]}};
            st_strb = 4'b0001 << alu_result_mem[1:0];
         end
         F3_SH[1:0]: begin
            st_data = {2{rs2_data_mem[15:0]}};
            st_strb = 4'b0011 << alu_result_mem[1:0];
         end
         default: begin
            st_data = rs2_data_mem;
            st_strb = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_pend       <= 1'b0;
         hold_st       <= HOLD_IDLE;
         held_q        <= '0;
         valid_wb      <= 1'b0;
         trap_wb       <= 1'b0;
         instr_wb      <= RV_NOP;
         res_src_wb    <= '0;
         funct3_wb     <= '0;
         alu_result_wb <= '0;
         rs1_data_wb   <= '0;
         rs2_data_wb   <= '0;
         pc_plus4_wb   <= '0;
         jb_target_wb  <= '0;
         csr_rdata_wb  <= '0;
         m_result_wb   <= '0;
         product_64_wb <= '0;
      end else begin
         ld_pend <= dmem.dmem_ren;
         // Read data is only valid in the first WB cycle; park it if WB cannot consume it
         case (hold_st)
            HOLD_IDLE: if (ld_pend && stall_mem) begin
               held_q  <= dmem.dmem_rdata;
               hold_st <= HOLD_HELD;
            end
            HOLD_HELD: if (!stall_mem) hold_st <= HOLD_IDLE;
            default:   hold_st <= HOLD_IDLE;
         endcase
         if (advance) begin
            valid_wb      <= keep;
            instr_wb      <= keep ? instr_mem : RV_NOP;
            trap_wb       <= keep & (trap_mem | (misaligned & (mem_read_mem | mem_write_mem)));
            res_src_wb    <= res_src_mem;
            funct3_wb     <= funct3_mem;
            alu_result_wb <= alu_result_mem;
            rs1_data_wb   <= rs1_data_mem;
            rs2_data_wb   <= rs2_data_mem;
            pc_plus4_wb   <= pc_plus4_mem;
            jb_target_wb  <= jb_target_mem;
            csr_rdata_wb  <= csr_rdata_mem;
            m_result_wb   <= m_result_mem;
            product_64_wb <= product_64_mem;
         end
      end
   end

   assign ld_word = (hold_st == HOLD_HELD) ? held_q : dmem.dmem_rdata;

   svc_rv_ld_ext #(.XLEN(XLEN)) u_ld_ext (
      .word   (ld_word),
      .addr   (alu_result_wb[1:0]),
      .funct3 (funct3_wb),
      .data   (dmem_rdata_ext_wb)
   );

endmodule

// File: tb/tb_svc_rv_stage_mem.sv
// Scoreboard bench for svc_rv_stage_mem: driver pushes expectations from a reference model,
// an independent monitor pops and compares against the DUT every cycle.
module tb_svc_rv_stage_mem;
   import svc_rv_stage_mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        valid_mem = 1'b0, mem_read_mem = 1'b0, mem_write_mem = 1'b0, trap_mem = 1'b0;
   logic [31:0] instr_mem = '0, alu_result_mem = '0, rs1_data_mem = '0, rs2_data_mem = '0;
   logic [31:0] pc_plus4_mem = '0, jb_target_mem = '0, csr_rdata_mem = '0, m_result_mem = '0;
   logic [2:0]  res_src_mem = '0, funct3_mem = '0;
   logic [63:0] product_64_mem = '0;
   logic        stall_mem = 1'b0, flush_mem = 1'b0;
   logic        valid_wb, trap_wb;
   logic [31:0] instr_wb, alu_result_wb, rs1_data_wb, rs2_data_wb, pc_plus4_wb;
   logic [31:0] jb_target_wb, csr_rdata_wb, m_result_wb, dmem_rdata_ext_wb;
   logic [2:0]  res_src_wb, funct3_wb;
   logic [63:0] product_64_wb;

   svc_rv_stage_mem_if #(.XLEN(32)) dmem ();

   svc_rv_stage_mem #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .valid_mem(valid_mem), .instr_mem(instr_mem), .res_src_mem(res_src_mem),
      .funct3_mem(funct3_mem), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
      .trap_mem(trap_mem), .alu_result_mem(alu_result_mem), .rs1_data_mem(rs1_data_mem),
      .rs2_data_mem(rs2_data_mem), .pc_plus4_mem(pc_plus4_mem), .jb_target_mem(jb_target_mem),
      .csr_rdata_mem(csr_rdata_mem), .m_result_mem(m_result_mem),
      .product_64_mem(product_64_mem), .stall_mem(stall_mem), .flush_mem(flush_mem),
      .dmem(dmem.master),
      .valid_wb(valid_wb), .instr_wb(instr_wb), .res_src_wb(res_src_wb), .funct3_wb(funct3_wb),
      .trap_wb(trap_wb), .alu_result_wb(alu_result_wb), .rs1_data_wb(rs1_data_wb),
      .rs2_data_wb(rs2_data_wb), .pc_plus4_wb(pc_plus4_wb), .jb_target_wb(jb_target_wb),
      .csr_rdata_wb(csr_rdata_wb), .m_result_wb(m_result_wb), .product_64_wb(product_64_wb),
      .dmem_rdata_ext_wb(dmem_rdata_ext_wb)
   );

   typedef struct {
      logic        valid, trap, chk_all, chk_ld;
      logic [31:0] instr, alu, rs2, pc4, mres, ld_val;
      logic [2:0]  res_src, f3;
      logic [63:0] prod;
   } wb_exp_t;

   typedef struct {
      logic        ren, we;
      logic [31:0] raddr, waddr, wdata;
      logic [3:0]  wstrb;
   } dm_exp_t;

   wb_exp_t     wb_q[$];
   dm_exp_t     dm_q[$];
   logic [31:0] env_mem[16];
   logic [31:0] ref_mem[16];
   int          n_tests = 0, n_fail = 0, we_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One MEM-stage cycle: drive inputs and record what the stage must do with them.
   task automatic step(input logic v, input logic [2:0] f3, input logic rd, input logic wr,
                       input logic tr, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic st, input logic fl, input logic r);
      dm_exp_t     d;
      wb_exp_t     e;
      int unsigned off, size, idx;
      logic        mis, bub, acc;
      logic [31:0] w, val;
      @(posedge clk);
      #1;
      rst = r; valid_mem = v; funct3_mem = f3; mem_read_mem = rd; mem_write_mem = wr;
      trap_mem = tr; alu_result_mem = addr; rs2_data_mem = rs2; stall_mem = st; flush_mem = fl;
      instr_mem = $urandom(); res_src_mem = 3'($urandom_range(0, 7));
      rs1_data_mem = $urandom(); pc_plus4_mem = $urandom(); jb_target_mem = $urandom();
      csr_rdata_mem = $urandom(); m_result_mem = $urandom();
      product_64_mem = {32'($urandom()), 32'($urandom())};

      off  = addr % 4;
      size = f3 % 4;
      idx  = (addr / 4) % 16;
      mis  = (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
      bub  = fl || !v;
      acc  = !r && !st && !bub && !mis;

      d.ren   = acc && rd;
      d.we    = acc && wr;
      d.raddr = addr - off;
      d.waddr = addr - off;
      d.wdata = (size == 0) ? rs2[7:0] * 32'h0101_0101 :
                (size == 1) ? rs2[15:0] * 32'h0001_0001 : rs2;
      d.wstrb = !d.we ? 4'd0 : (size == 0) ? 4'(1 << off) : (size == 1) ? 4'(3 << off) : 4'hF;
      if (d.we)
         for (int j = 0; j < 4; j++)
            if (d.wstrb[j]) ref_mem[idx][8*j +: 8] = d.wdata[8*j +: 8];
      dm_q.push_back(d);

      if (!r && !st) begin
         w   = ref_mem[idx];
         val = w;
         if (size == 0) begin
            val = (w >> (8 * off)) & 32'hFF;
            if (!f3[2] && val >= 128) val = val - 256;
         end else if (size == 1) begin
            val = (w >> (8 * off)) & 32'hFFFF;
            if (!f3[2] && val >= 32768) val = val - 65536;
         end
         e.valid   = !bub;
         e.instr   = bub ? RV_NOP : instr_mem;
         e.trap    = bub ? 1'b0 : (tr || (mis && (rd || wr)));
         e.chk_all = !bub;
         e.chk_ld  = d.ren;
         e.ld_val  = val;
         e.alu = addr; e.rs2 = rs2; e.pc4 = pc_plus4_mem; e.mres = m_result_mem;
         e.res_src = res_src_mem; e.f3 = f3; e.prod = product_64_mem;
         wb_q.push_back(e);
      end
   endtask

   // Memory model: read data one cycle after ren, garbage otherwise
   initial begin
      logic        ren_s, we_s;
      logic [31:0] ra, wa, wd;
      logic [3:0]  ws;
      dmem.dmem_rdata = '0;
      forever begin
         @(posedge clk);
         ren_s = dmem.dmem_ren; ra = dmem.dmem_raddr;
         we_s = dmem.dmem_we; wa = dmem.dmem_waddr; wd = dmem.dmem_wdata; ws = dmem.dmem_wstrb;
         if (we_s)
            for (int j = 0; j < 4; j++)
               if (ws[j]) env_mem[wa[5:2]][8*j +: 8] = wd[8*j +: 8];
         #1;
         dmem.dmem_rdata = ren_s ? env_mem[ra[5:2]] : $urandom();
      end
   end

   // Monitor
   initial begin
      wb_exp_t cur;
      dm_exp_t d;
      logic    adv_s, rst_s;
      cur = '{valid: 1'b0, trap: 1'b0, chk_all: 1'b0, chk_ld: 1'b0, instr: RV_NOP,
              alu: '0, rs2: '0, pc4: '0, mres: '0, ld_val: '0, res_src: '0, f3: '0, prod: '0};
      forever begin
         @(posedge clk);
         adv_s = !stall_mem;
         rst_s = rst;
         @(negedge clk);
         if (rst_s) begin
            cur = '{valid: 1'b0, trap: 1'b0, chk_all: 1'b1, chk_ld: 1'b0, instr: RV_NOP,
                    alu: '0, rs2: '0, pc4: '0, mres: '0, ld_val: '0, res_src: '0, f3: '0,
                    prod: '0};
         end else if (adv_s) begin
            if (wb_q.size() == 0) check("wb_q_underflow", 64'd1, 64'd0);
            else cur = wb_q.pop_front();
         end
         check("valid_wb", 64'(valid_wb), 64'(cur.valid));
         check("instr_wb", 64'(instr_wb), 64'(cur.instr));
         check("trap_wb", 64'(trap_wb), 64'(cur.trap));
         if (cur.chk_all) begin
            check("alu_result_wb", 64'(alu_result_wb), 64'(cur.alu));
            check("rs2_data_wb", 64'(rs2_data_wb), 64'(cur.rs2));
            check("pc_plus4_wb", 64'(pc_plus4_wb), 64'(cur.pc4));
            check("m_result_wb", 64'(m_result_wb), 64'(cur.mres));
            check("res_src_wb", 64'(res_src_wb), 64'(cur.res_src));
            check("funct3_wb", 64'(funct3_wb), 64'(cur.f3));
            check("product_64_wb", product_64_wb, cur.prod);
         end
         if (cur.chk_ld) check("dmem_rdata_ext_wb", 64'(dmem_rdata_ext_wb), 64'(cur.ld_val));
         if (dmem.dmem_we) we_cnt++;
         if (dm_q.size() != 0) begin
            d = dm_q.pop_front();
            check("dmem_ren", 64'(dmem.dmem_ren), 64'(d.ren));
            check("dmem_we", 64'(dmem.dmem_we), 64'(d.we));
            check("dmem_wstrb", 64'(dmem.dmem_wstrb), 64'(d.wstrb));
            if (d.ren) check("dmem_raddr", 64'(dmem.dmem_raddr), 64'(d.raddr));
            if (d.we) begin
               check("dmem_waddr", 64'(dmem.dmem_waddr), 64'(d.waddr));
               check("dmem_wdata", 64'(dmem.dmem_wdata), 64'(d.wdata));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          we_before;
      logic [2:0]  f3;
      logic        rd, wr;
      int unsigned op;
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = $urandom();
         ref_mem[i] = env_mem[i];
      end
      //       v  f3      rd wr tr addr          rs2           st fl r
      step(0, F3_LW,  0, 0, 0, 32'h0,       32'h0,        0, 0, 1);
      step(0, F3_LW,  0, 0, 0, 32'h0,       32'h0,        0, 0, 1);
      step(1, F3_SW,  0, 1, 0, 32'h100,     32'hDEADBEEF, 0, 0, 0);
      step(1, F3_SB,  0, 1, 0, 32'h103,     32'h0000_00A5, 0, 0, 0);
      step(1, F3_SW,  0, 1, 0, 32'h200,     32'h80FF7F01, 0, 0, 0);
      step(1, F3_LB,  1, 0, 0, 32'h203,     32'h0,        0, 0, 0);
      step(1, F3_LBU, 1, 0, 0, 32'h203,     32'h0,        0, 0, 0);
      step(1, F3_LH,  1, 0, 0, 32'h202,     32'h0,        0, 0, 0);
      step(1, F3_LHU, 1, 0, 0, 32'h200,     32'h0,        0, 0, 0);
      step(1, F3_LW,  1, 0, 0, 32'h102,     32'h0,        0, 0, 0);
      step(1, F3_SH,  0, 1, 0, 32'h101,     32'h1234,     0, 0, 0);
      // Load parked under a 3-cycle stall, store held behind it
      step(1, F3_LW,  1, 0, 0, 32'h200,     32'h0,        0, 0, 0);
      we_before = we_cnt;
      repeat (3) step(1, F3_SW, 0, 1, 0, 32'h208, 32'hCAFEF00D, 1, 0, 0);
      step(1, F3_SW,  0, 1, 0, 32'h208,     32'hCAFEF00D, 0, 0, 0);
      step(0, F3_LW,  0, 0, 0, 32'h0,       32'h0,        0, 0, 0);
      @(negedge clk);
      #1;
      check("single_we_pulse", 64'(we_cnt - we_before), 64'd1);
      // Flush of an advancing store, then flush ignored under stall
      step(1, F3_SW,  0, 1, 0, 32'h20C,     32'h11111111, 0, 1, 0);
      step(1, F3_LW,  1, 0, 0, 32'h204,     32'h0,        1, 1, 0);
      step(1, F3_LW,  1, 0, 0, 32'h204,     32'h0,        0, 0, 0);
      // Reset while load data is held
      step(1, F3_LW,  1, 0, 0, 32'h208,     32'h0,        0, 0, 0);
      step(0, F3_LW,  0, 0, 0, 32'h0,       32'h0,        1, 0, 0);
      step(0, F3_LW,  0, 0, 0, 32'h0,       32'h0,        1, 0, 0);
      step(0, F3_LW,  0, 0, 0, 32'h0,       32'h0,        1, 0, 1);
      step(1, F3_LH,  1, 0, 0, 32'h20A,     32'h0,        0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 2);
         rd = (op == 0);
         wr = (op == 1);
         if (wr) f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = F3_LHU;
         end
         step($urandom_range(0, 7) != 0, f3, rd, wr, $urandom_range(0, 15) == 0,
              32'h200 + 32'($urandom_range(0, 63)), $urandom(),
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end
      repeat (3) step(0, F3_LW, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check("wb_q_drained", 64'(wb_q.size()), 64'd0);
      check("dm_q_drained", 64'(dm_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/svc_rv_stage_mem.md
SVC_RV_STAGE_MEM -- requirements
Module: svc_rv_stage_mem

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports clk (in, 1, clock) and rst (in, 1, synchronous active-high reset); one clock, reset synchronous and active-high.
REQ-003 SHALL have EX/MEM inputs, all sampled when the stage advances: valid_mem 1, instr_mem 32, res_src_mem 3, funct3_mem 3, mem_read_mem 1, mem_write_mem 1, trap_mem 1, alu_result_mem XLEN (also the memory address), rs1_data_mem, rs2_data_mem, pc_plus4_mem, jb_target_mem, csr_rdata_mem, m_result_mem XLEN each, product_64_mem 64.
REQ-004 SHALL have pipeline control inputs stall_mem (1, hold MEM/WB register) and flush_mem (1, turn the advancing instruction into a bubble).
REQ-005 SHALL have dmem outputs dmem_ren 1, dmem_raddr XLEN, dmem_we 1, dmem_waddr XLEN, dmem_wdata XLEN, dmem_wstrb 4; SHALL have input dmem_rdata XLEN, valid exactly one cycle after dmem_ren.
REQ-006 SHALL have WB outputs valid_wb, instr_wb, res_src_wb, funct3_wb, trap_wb, alu_result_wb, rs1_data_wb, rs2_data_wb, pc_plus4_wb, jb_target_wb, csr_rdata_wb, m_result_wb, product_64_wb (registered) and dmem_rdata_ext_wb XLEN (combinational from load data).

Function
REQ-007 SHALL advance (capture all *_mem into *_wb) on every cycle with stall_mem=0; with stall_mem=1 SHALL hold all *_wb registers.
REQ-008 SHALL, when advancing with flush_mem=1 or valid_mem=0, load a bubble: valid_wb=0, trap_wb=0, instr_wb=0x00000013 (NOP), no dmem access.
REQ-009 SHALL detect misalignment from funct3_mem[1:0] and alu_result_mem[1:0]: halfword with addr[0]=1, word with addr[1:0]!=0; byte never misaligned.
REQ-010 SHALL set trap_wb = trap_mem OR (misaligned AND (mem_read_mem OR mem_write_mem)) for valid, non-flushed advancing instructions.
REQ-011 SHALL assert dmem_ren only when advancing, valid, not flushed, mem_read_mem=1, not misaligned; dmem_raddr = alu_result_mem with bits [1:0] cleared.
REQ-012 SHALL assert dmem_we only under the same conditions with mem_write_mem=1; never more than once per instruction regardless of stall length.
REQ-013 SHALL set dmem_wdata: SB replicates rs2[7:0] to all four lanes, SH replicates rs2[15:0] to both halves, SW passes rs2; dmem_wstrb: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; wstrb=0 whenever dmem_we=0.
REQ-014 SHALL produce dmem_rdata_ext_wb from load data using funct3_wb and alu_result_wb[1:0]: LB/LBU select byte lane, LH/LHU select halfword, LW full word; funct3_wb[2]=0 sign-extends, =1 zero-extends.
REQ-015 SHALL implement a load-hold buffer with states IDLE and HELD: in IDLE, load data = dmem_rdata; in the first cycle after a load advances into WB, if stall_mem=1, capture dmem_rdata and go to HELD.
REQ-016 SHALL, in HELD, use the captured word as load data; SHALL return to IDLE on the first cycle with stall_mem=0 (WB consumes held data that cycle).
REQ-017 SHALL give flush_mem no effect while stall_mem=1 (stall wins; the flush is re-presented by the hazard unit).
REQ-018 SHALL keep dmem_rdata_ext_wb undefined-safe (deterministic, derived from held/current data) when res_src_wb does not select load data.

Reset
REQ-019 SHALL, on rst=1 at a clk edge, set valid_wb=0, trap_wb=0, instr_wb=0x00000013, res_src_wb=0, funct3_wb=0, all XLEN/64-bit *_wb registers=0, hold buffer=IDLE with data 0.
REQ-020 SHALL hold dmem_ren=0, dmem_we=0, dmem_wstrb=0 while rst=1; reset mid-stall SHALL drop held data and any pending load.

Structure
REQ-021 SHALL take funct3 load/store encodings and the NOP/EBREAK instruction constants from the shared RISC-V defs; no local copies.
REQ-022 SHALL place load extraction/sign-extension in one combinational sub-module svc_rv_ld_ext (inputs word, addr[1:0], funct3; output XLEN); all sequential logic stays in svc_rv_stage_mem.

Verification
REQ-023 SW x=0xDEADBEEF to 0x100 -> one cycle dmem_we=1, waddr=0x100, wdata=0xDEADBEEF, wstrb=4'b1111; SB 0xA5 to 0x103 -> wdata=0xA5A5A5A5, wstrb=4'b1000.
REQ-024 Memory word 0x80FF7F01 at 0x200; LB 0x203 -> 0xFFFFFF80; LBU 0x203 -> 0x00000080; LH 0x202 -> 0xFFFF80FF; LHU 0x200 -> 0x00007F01.
REQ-025 LW to 0x102 -> no dmem_ren, trap_wb=1, valid_wb=1; SH to 0x101 -> no dmem_we, trap_wb=1.
REQ-026 LW advances, stall_mem=1 for 3 cycles while dmem_rdata changes to garbage after cycle 1 -> dmem_rdata_ext_wb stays the cycle-1 word throughout; SW held in MEM under 3-cycle stall -> exactly one dmem_we pulse.
REQ-027 flush_mem=1 on advancing SW -> dmem_we=0, valid_wb=0, instr_wb=0x00000013; flush_mem with stall_mem=1 -> *_wb unchanged.
REQ-028 rst asserted during HELD -> next cycle valid_wb=0, trap_wb=0, instr_wb=0x00000013, hold state IDLE.
